rca_mult_seq: RTL
=================

Name: rca_mult_seq

Overview:
- Sequential shift-and-add unsigned multiplier.
- Time-multiplexes one SIZE-bit ripple-carry adder (the team's FAnbit_RCA instance, Cin tied 0) over SIZE iterations to form a 2*SIZE-bit product.
- Sits between board-level operand switches/registers and the display path on the Nexys A7-100T.
- Start/busy/done handshake; product held until next accepted start.

Parameters:
SIZE, 4, operand width in bits (>=2); adder width; iteration count.

Ports:
PortClk  input  1  system clock, rising-edge.
PortRst_n  input  1  asynchronous active-low reset.
PortStart  input  1  request; sampled only in IDLE.
PortA  input  SIZE  multiplicand, unsigned; captured on accepted start.
PortB  input  SIZE  multiplier, unsigned; captured on accepted start.
PortBusy  output  1  high while state != IDLE.
PortDone  output  1  one-cycle pulse: product valid.
PortP  output  2*SIZE  registered product.

Behaviour:
- One clock (PortClk); reset asynchronous, active-low (PortRst_n). All flops clear immediately on PortRst_n=0.
- Reset values: state=IDLE, PortBusy=0, PortDone=0, PortP=0, internal regs/counter=0.
- Registers:
  - mcand[SIZE-1:0]
  - acc[SIZE-1:0], the high half
  - q[SIZE-1:0], the low half and multiplier
  - cnt, width clog2(SIZE)
- States: IDLE, RUN, DONE.
- IDLE:
  - PortStart=1 at an edge: mcand<=PortA, q<=PortB, acc<=0, cnt<=SIZE-1, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - Adder inputs are acc and (q[0] ? mcand : 0). Adder gives sum s and carry c.
  - {acc,q} <= {c, s, q[SIZE-1:1]}, a right shift by 1 of the (SIZE+1)-bit sum concatenated with q.
  - cnt decrements each cycle.
  - When cnt==0 in RUN: load PortP <= final {acc,q} value (the next-state value, not the current one). On the same edge set PortDone<=1 and go to DONE.
- DONE:
  - Lasts exactly one cycle with PortDone=1, then goes to IDLE and PortDone returns to 0.
- Latency:
  - Start sampled at edge t0.
  - RUN occupies the SIZE cycles after t0.
  - PortDone and the new PortP are visible in the cycle after edge t0+SIZE.
  - Total: SIZE+1 edges from start sampling to done cycle. PortBusy is high for SIZE+1 cycles.
- Arithmetic:
  - Unsigned. The adder carry-out is never dropped; it becomes the MSB of acc after the shift.
  - Maximum result (2^SIZE-1)^2 fits in 2*SIZE bits.
- PortP changes only on the final RUN edge or on reset. It is stable through IDLE and DONE and during a subsequent RUN until that run's final edge.
- PortStart in RUN or DONE: ignored, not queued. Inputs may change freely while busy.
- PortStart held high continuously: a new operation is accepted at the first IDLE edge. Back-to-back period is SIZE+2 cycles.
- Reset asserted mid-RUN/DONE: operation aborted, PortDone not pulsed, PortP=0, state=IDLE.
- Zero operands: still take the full SIZE iterations (no early exit); result 0.

Test Plan:
- SIZE=4, reset, then A=13, B=11, start pulsed 1 cycle -> PortBusy=1 for 5 cycles; PortDone single pulse exactly 5 edges after start edge; PortP=143 (0x8F) and holds afterward.
- SIZE=4, A=15, B=15 -> PortP=225 (0xE1). Carry-out path exercised; A=0,B=9 and A=7,B=0 -> PortP=0 with the same latency.
- SIZE=4, A=3, B=5 started; during RUN drive PortStart=1 with A=9, B=9 -> ignored; PortP=15, one PortDone only.
- SIZE=4, PortStart held high, A=2,B=3 then A=6,B=7 changed while busy -> successive results 6 then 42. Second PortDone occurs 6 cycles after the first.
- SIZE=4, start A=12,B=10, assert PortRst_n=0 asynchronously (between edges) in the 3rd RUN cycle -> PortBusy, PortDone, PortP go 0 immediately. After release, IDLE with no done pulse; next start A=12,B=10 -> 120.
- SIZE=8, A=255, B=255 -> PortP=65025 (0xFE01) after 9 edges; random 200-vector sweep vs. A*B reference model.

Source files
------------

// File: rtl/rca_mult_seq.sv
// Sequential shift-and-add unsigned multiplier: one SIZE-bit ripple-carry adder
// reused for SIZE iterations to build a 2*SIZE-bit product.

module rca_nbit #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  logic carry;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < SIZE; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module rca_mult_seq #(
  parameter int SIZE = 4
) (
  input  logic              PortClk,
  input  logic              PortRst_n,
  input  logic              PortStart,
  input  logic [SIZE-1:0]   PortA,
  input  logic [SIZE-1:0]   PortB,
  output logic              PortBusy,
  output logic              PortDone,
  output logic [2*SIZE-1:0] PortP
);

  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] mcand;
  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] q;
  logic [CW-1:0]   cnt;

  logic [SIZE-1:0] addend;
  logic [SIZE-1:0] sum;
  logic            cout;
  logic [SIZE-1:0] acc_nxt;
  logic [SIZE-1:0] q_nxt;

  assign addend = q[0] ? mcand : '0;

  rca_nbit #(.SIZE(SIZE)) u_adder (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Right shift of {cout, sum, q}: the carry-out lands in the MSB of acc.
  assign acc_nxt = {cout, sum[SIZE-1:1]};
  assign q_nxt   = {sum[0], q[SIZE-1:1]};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge PortClk or negedge PortRst_n) begin
    if (!PortRst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (PortStart) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PortClk or negedge PortRst_n) begin
    if (!PortRst_n) begin
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      PortP <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (PortStart) begin
            mcand <= PortA;
            q     <= PortB;
            acc   <= '0;
            cnt   <= CW'(SIZE - 1);
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt - CW'(1);
          // The product register takes the post-shift value of the last iteration.
          if (cnt == '0) PortP <= {acc_nxt, q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign PortBusy = (state != IDLE);
  assign PortDone = (state == DONE);

endmodule
